// File: rtl/req_grant_pkg.sv
// Shared types and helpers for the multi-channel request/grant responder.
package req_grant_pkg;

    localparam int CHN_MAX = 16;
    localparam int PICK_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } rg_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set request at or above ptr, wrapping modulo n.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [CHN_MAX-1:0] req,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        logic [PICK_W-1:0] r;
        logic              found;
        int                j;
        r     = ptr;
        found = 1'b0;
        for (int i = 0; i < CHN_MAX; i++) begin
            j = int'(ptr) + i;
            if (j >= n) j = j - n;
            if (!found && i < n && req[j[PICK_W-1:0]]) begin
                r     = j[PICK_W-1:0];
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/req_grant_pld_fifo.sv
// Synchronous payload FIFO with occupancy count; no push-to-pop bypass.
module req_grant_pld_fifo
    import req_grant_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_cnt
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_head  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/req_grant_responder_mc.sv
// Round-robin multi-channel grant responder with per-channel grant latency.
module req_grant_responder_mc
    import req_grant_pkg::*;
#(
    parameter  int CHN_N         = 4,
    parameter  int PAYLOAD_WIDTH = 32,
    parameter  int FIFO_DEPTH    = 4,
    parameter  int WAIT_W        = 3,
    localparam int IDX_W         = idx_w(CHN_N),
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PAYLOAD_WIDTH-1:0]  pld_in,
    input  logic                      pld_in_vld,
    output logic                      pld_in_rdy,
    output logic [CW-1:0]             fifo_cnt,
    input  logic [CHN_N*WAIT_W-1:0]   wait_cfg,
    input  logic [CHN_N-1:0]          req,
    output logic [CHN_N-1:0]          grant,
    output logic [IDX_W-1:0]          grant_id,
    output logic [PAYLOAD_WIDTH-1:0]  payload
);

    rg_state_e          r_state;
    logic [IDX_W-1:0]   r_sel;
    logic [WAIT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic [PAYLOAD_WIDTH-1:0] w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_arb;
    logic [IDX_W-1:0]         w_win;
    logic [WAIT_W-1:0]        w_k;
    logic                     w_pop;

    function automatic logic [IDX_W-1:0] f_nxt(input logic [IDX_W-1:0] i);
        return (int'(i) == CHN_N - 1) ? '0 : i + IDX_W'(1);
    endfunction

    req_grant_pld_fifo #(
        .W     (PAYLOAD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (pld_in_vld & pld_in_rdy & ~rst),
        .i_data  (pld_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (fifo_cnt)
    );

    assign pld_in_rdy = ~w_full;
    assign w_arb = (r_state == IDLE) & ~w_empty & (|req) & ~rst;
    assign w_win = IDX_W'(rr_pick(CHN_MAX'(req), PICK_W'(r_rr_ptr), CHN_N));
    assign w_k   = wait_cfg[int'(w_win)*WAIT_W +: WAIT_W];

    // Zero-latency grants fire straight out of IDLE; others wait for GRANT.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (w_arb && w_k == '0) begin
            grant    = CHN_N'(1) << w_win;
            grant_id = w_win;
        end else if (!rst && r_state == GRANT && req[r_sel]) begin
            grant    = CHN_N'(1) << r_sel;
            grant_id = r_sel;
        end
    end

    assign w_pop   = |grant;
    assign payload = w_pop ? w_head : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb) begin
                        if (w_k == '0) begin
                            r_rr_ptr <= f_nxt(w_win);
                        end else if (w_k == WAIT_W'(1)) begin
                            r_sel   <= w_win;
                            r_state <= GRANT;
                        end else begin
                            r_sel   <= w_win;
                            r_cnt   <= w_k - WAIT_W'(2);
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req[r_sel])        r_state <= IDLE;
                    else if (r_cnt == '0)   r_state <= GRANT;
                    else                    r_cnt   <= r_cnt - WAIT_W'(1);
                end
                GRANT: begin
                    if (req[r_sel]) r_rr_ptr <= f_nxt(r_sel);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_grant_responder_mc.sv
// Directed bench for req_grant_responder_mc (4 channels, depth-4 FIFO).
module tb_req_grant_responder_mc;

    logic        clk;
    logic        rst;
    logic [31:0] pld_in;
    logic        pld_in_vld;
    logic        pld_in_rdy;
    logic [2:0]  fifo_cnt;
    logic [11:0] wait_cfg;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic [31:0] payload;

    int n_vec;
    int n_bad;

    req_grant_responder_mc #(
        .CHN_N         (4),
        .PAYLOAD_WIDTH (32),
        .FIFO_DEPTH    (4),
        .WAIT_W        (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pld_in     (pld_in),
        .pld_in_vld (pld_in_vld),
        .pld_in_rdy (pld_in_rdy),
        .fifo_cnt   (fifo_cnt),
        .wait_cfg   (wait_cfg),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .payload    (payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, then settle comb outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        pld_in     = d;
        pld_in_vld = 1'b1;
        step();
        pld_in_vld = 1'b0;
        #1;
    endtask

    task automatic chk_g(input string tag, input logic [3:0] g,
                         input logic [1:0] id, input logic [31:0] p);
        chk({tag, ".grant"}, 64'(grant), 64'(g));
        chk({tag, ".id"}, 64'(grant_id), 64'(id));
        chk({tag, ".pld"}, 64'(payload), 64'(p));
    endtask

    initial begin
        logic [3:0] g_exp;
        n_vec      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        pld_in     = '0;
        pld_in_vld = 1'b0;
        wait_cfg   = '0;
        req        = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_g("rst", 4'b0000, 2'd0, 32'h0);
        chk("rst.rdy", 64'(pld_in_rdy), 64'd1);
        chk("rst.cnt", 64'(fifo_cnt), 64'd0);

        // Zero latency, all channels: one grant per cycle in rotation
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        chk("t1.cnt", 64'(fifo_cnt), 64'd4);
        req = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            g_exp = 4'(1 << i);
            chk_g("t1", g_exp, 2'(i), 32'hA0 + 32'(i));
            step();
        end
        chk_g("t1.empty", 4'b0000, 2'd0, 32'h0);
        chk("t1.cnt0", 64'(fifo_cnt), 64'd0);
        req = '0;

        // Fairness: ch0/ch2 alternate
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        req = 4'b0101;
        #1;
        for (int i = 0; i < 4; i++) begin
            g_exp = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            chk_g("fair", g_exp, (i % 2 == 0) ? 2'd0 : 2'd2,
                  32'hB0 + 32'(i));
            step();
        end
        req = '0;

        // ch2 latency 3: grant three cycles after first request
        wait_cfg = 12'h0C0;
        push(32'h55);
        req = 4'b0100;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk_g("lat3.wait", 4'b0000, 2'd0, 32'h0);
            step();
        end
        chk_g("lat3.grant", 4'b0100, 2'd2, 32'h55);
        step();
        chk_g("lat3.after", 4'b0000, 2'd0, 32'h0);
        chk("lat3.cnt", 64'(fifo_cnt), 64'd0);
        req = '0;

        // Abort: ch1 latency 4, drop in WAIT; rr_ptr must stay at 3
        wait_cfg = 12'h020;
        push(32'h77);
        req = 4'b0010;
        #1;
        chk_g("abort.t0", 4'b0000, 2'd0, 32'h0);
        step();
        chk_g("abort.t1", 4'b0000, 2'd0, 32'h0);
        step();
        req = 4'b0000;
        #1;
        chk_g("abort.drop", 4'b0000, 2'd0, 32'h0);
        step();
        chk("abort.cnt", 64'(fifo_cnt), 64'd1);
        // ch1 must beat ch2 from ptr 3; ch2 has zero latency
        req = 4'b0110;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_g("abort.rewait", 4'b0000, 2'd0, 32'h0);
            step();
        end
        chk_g("abort.grant", 4'b0010, 2'd1, 32'h77);
        step();
        chk_g("abort.after", 4'b0000, 2'd0, 32'h0);
        chk("abort.cnt0", 64'(fifo_cnt), 64'd0);
        req = '0;

        // FIFO full boundary and full push with same-cycle pop
        wait_cfg = '0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("full.rdy", 64'(pld_in_rdy), 64'd1);
            push(32'hC0 + 32'(i));
        end
        chk("full.cnt", 64'(fifo_cnt), 64'd4);
        chk("full.rdy0", 64'(pld_in_rdy), 64'd0);
        push(32'hC4);
        chk("full.cnt5", 64'(fifo_cnt), 64'd4);
        pld_in     = 32'hC5;
        pld_in_vld = 1'b1;
        req        = 4'b0001;
        #1;
        chk("full.rdypop", 64'(pld_in_rdy), 64'd0);
        chk_g("full.pop", 4'b0001, 2'd0, 32'hC0);
        step();
        pld_in_vld = 1'b0;
        req        = '0;
        #1;
        chk("full.cnt3", 64'(fifo_cnt), 64'd3);
        req = 4'b0001;
        #1;
        for (int i = 1; i < 4; i++) begin
            chk_g("full.drain", 4'b0001, 2'd0, 32'hC0 + 32'(i));
            step();
        end
        chk_g("full.empty", 4'b0000, 2'd0, 32'h0);
        req = '0;

        // Reset during WAIT discards the transaction
        wait_cfg = 12'h005;
        push(32'hD0);
        req = 4'b0001;
        #1;
        chk_g("rstw.t0", 4'b0000, 2'd0, 32'h0);
        step();
        step();
        rst        = 1'b1;
        pld_in     = 32'hDD;
        pld_in_vld = 1'b1;
        #1;
        chk_g("rstw.inrst", 4'b0000, 2'd0, 32'h0);
        step();
        rst        = 1'b0;
        pld_in_vld = 1'b0;
        #1;
        chk("rstw.cnt", 64'(fifo_cnt), 64'd0);
        chk("rstw.rdy", 64'(pld_in_rdy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk_g("rstw.nogrant", 4'b0000, 2'd0, 32'h0);
            step();
        end
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
